// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store sequencer between a multi-cycle datapath and a unified,
//   word-addressed memory (combinational read, write on posedge clk).
//   Handles RV32I LB/LH/LW/LBU/LHU/SB/SH/SW. Loads are extended by lane.
//   Sub-word stores do a read-modify-write. Misaligned accesses (when
//   CHECK_ALIGN=1) and illegal funct3 values complete with err.
//
// Ports
//   clk, rst               clock and synchronous active-high reset
//   req_valid, req_we      request strobe (taken only when ready) / 1=store
//   funct3, addr, wdata    RV32I width code, byte address, store data
//   ready, done, err       idle flag, one-cycle completion pulse, error with done
//   rdata                  extended load result, held until the next load
//   mem_A, mem_WD, mem_WE  word-aligned memory address, write word, write enable
//   mem_RD                 memory read data (combinational from mem_A)
module mem_access_unit #(
  parameter int ADDR_W      = 32,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mem_A,
  output logic [31:0]       mem_WD,
  output logic              mem_WE,
  input  logic [31:0]       mem_RD
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_f3;
  logic [31:0]       r_wdata;
  logic              r_we;
  logic              r_err;
  logic [31:0]       r_word;
  logic [31:0]       r_rdata;

  logic w_illegal;
  logic w_misalign;
  logic w_dec_err;
  logic w_accept;

  // Select the addressed lane and extend it to 32 bits.
  function automatic logic [31:0] load_ext(input logic [31:0] word,
                                           input logic [1:0]  a,
                                           input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = a[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  load_ext = {{24{b[7]}}, b};
      3'b100:  load_ext = {24'd0, b};
      3'b001:  load_ext = {{16{h[15]}}, h};
      3'b101:  load_ext = {16'd0, h};
      default: load_ext = word;
    endcase
  endfunction

  // Merge store data into the previously read word (SW replaces it whole).
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [31:0] wd,
                                              input logic [1:0]  a,
                                              input logic [2:0]  f3);
    logic [31:0] m;
    m = word;
    case (f3[1:0])
      2'b00: begin
        case (a)
          2'd0:    m[7:0]   = wd[7:0];
          2'd1:    m[15:8]  = wd[7:0];
          2'd2:    m[23:16] = wd[7:0];
          default: m[31:24] = wd[7:0];
        endcase
      end
      2'b01: begin
        if (a[1]) m[31:16] = wd[15:0];
        else      m[15:0]  = wd[15:0];
      end
      default: m = wd;
    endcase
    store_merge = m;
  endfunction

  // Unsigned variants only exist for loads; 011/11x are undefined widths.
  assign w_illegal  = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) ||
                      (funct3[2] && req_we);
  // With CHECK_ALIGN=0 the low bits are simply ignored when lanes are picked.
  assign w_misalign = CHECK_ALIGN &&
                      (((funct3[1:0] == 2'b01) && addr[0]) ||
                       ((funct3 == 3'b010) && (addr[1:0] != 2'b00)));
  assign w_dec_err  = w_illegal || w_misalign;
  assign w_accept   = (r_state == S_IDLE) && req_valid;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (w_dec_err)                 w_next = S_DONE;
          else if (!req_we)              w_next = S_READ;
          else if (funct3[1:0] == 2'b10) w_next = S_WRITE;
          else                           w_next = S_READ;
        end
      end
      S_READ:  w_next = r_we ? S_WRITE : S_DONE;
      S_WRITE: w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_err   <= 1'b0;
      r_rdata <= 32'd0;
      r_addr  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_err  <= w_dec_err;
        r_addr <= addr;
      end
      // Load result is extended straight from the memory read in READ.
      if ((r_state == S_READ) && !r_we)
        r_rdata <= load_ext(mem_RD, r_addr[1:0], r_f3);
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_f3    <= funct3;
      r_wdata <= wdata;
      r_we    <= req_we;
    end
    if (r_state == S_READ)
      r_word <= mem_RD;
  end

  assign ready  = (r_state == S_IDLE)  && !rst;
  assign done   = (r_state == S_DONE)  && !rst;
  assign err    = done && r_err;
  // A reset arriving during WRITE must suppress the write.
  assign mem_WE = (r_state == S_WRITE) && !rst;
  assign mem_WD = store_merge(r_word, r_wdata, r_addr[1:0], r_f3);
  assign mem_A  = rst ? '0 : {r_addr[ADDR_W-1:2], 2'b00};
  assign rdata  = r_rdata;

endmodule
